// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, operation IDs, immediate formats and
// the decoded-entry struct. RV32M IDs are used only when DECODE_RV32M_EN is defined.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_we;
        logic       rs1_used;
        logic       rs2_used;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: builds the 32-bit immediate for the given format and
// sign-extends it to XLEN. Independent of DECODE_RV32M_EN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (imm_fmt_e'(fmt))
            FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'(signed'(raw));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer on valid/ready handshakes.
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide group instead of trapping it.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic [XLEN-1:0] out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        dec_t            dec;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    op_e        op;
    imm_fmt_e   fmt;
    logic       wr, rd1, rd2;
    logic [XLEN-1:0] imm;
    entry_t     in_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        op  = OP_ILLEGAL;
        fmt = FMT_R;
        wr  = 1'b0;
        rd1 = 1'b0;
        rd2 = 1'b0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; wr = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; wr = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; wr = 1'b1; end
            OPC_JALR: begin
                fmt = FMT_I; wr = 1'b1; rd1 = 1'b1;
                if (funct3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B; rd1 = 1'b1; rd2 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I; wr = 1'b1; rd1 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S; rd1 = 1'b1; rd2 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I; wr = 1'b1; rd1 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_ADDI;
                    3'b010:  op = OP_SLTI;
                    3'b011:  op = OP_SLTIU;
                    3'b100:  op = OP_XORI;
                    3'b110:  op = OP_ORI;
                    3'b111:  op = OP_ANDI;
                    3'b001:  if (funct7 == 7'h00) op = OP_SLLI;
                    default: begin
                        if (funct7 == 7'h00)      op = OP_SRLI;
                        else if (funct7 == 7'h20) op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                wr = 1'b1; rd1 = 1'b1; rd2 = 1'b1;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'b000)      op = OP_SUB;
                    else if (funct3 == 3'b101) op = OP_SRA;
                end
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01) begin
                    case (funct3)
                        3'b000:  op = OP_MUL;
                        3'b001:  op = OP_MULH;
                        3'b010:  op = OP_MULHSU;
                        3'b011:  op = OP_MULHU;
                        3'b100:  op = OP_DIV;
                        3'b101:  op = OP_DIVU;
                        3'b110:  op = OP_REM;
                        default: op = OP_REMU;
                    endcase
                end
`endif
            end
            OPC_MISC_MEM: begin
                fmt = FMT_I;
                if (funct3 == 3'b000) op = OP_FENCE;
            end
            OPC_SYSTEM: begin
                fmt = FMT_I;
                if (in_instr == 32'h0000_0073)      op = OP_ECALL;
                else if (in_instr == 32'h0010_0073) op = OP_EBREAK;
            end
            default: op = OP_ILLEGAL;
        endcase
        // Illegal words travel with no side effects and a zero immediate.
        if (op == OP_ILLEGAL) begin
            fmt = FMT_R;
            wr  = 1'b0;
            rd1 = 1'b0;
            rd2 = 1'b0;
        end
    end

    rv_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr(in_instr),
        .fmt  (fmt),
        .imm  (imm)
    );

    always_comb begin
        in_entry.dec.op       = op;
        in_entry.dec.rd       = in_instr[11:7];
        in_entry.dec.rs1      = in_instr[19:15];
        in_entry.dec.rs2      = in_instr[24:20];
        in_entry.dec.rd_we    = wr && (in_instr[11:7] != 5'd0);
        in_entry.dec.rs1_used = rd1;
        in_entry.dec.rs2_used = rd2;
        in_entry.dec.illegal  = (op == OP_ILLEGAL);
        in_entry.imm          = imm;
        in_entry.pc           = in_pc;
    end

    logic [1:0] state_q, state_d;
    entry_t     main_q, main_d, skid_q, skid_d;
    logic       accept, pop;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_op       = main_q.dec.op;
    assign out_rd       = main_q.dec.rd;
    assign out_rs1      = main_q.dec.rs1;
    assign out_rs2      = main_q.dec.rs2;
    assign out_rd_we    = main_q.dec.rd_we;
    assign out_rs1_used = main_q.dec.rs1_used;
    assign out_rs2_used = main_q.dec.rs2_used;
    assign out_imm      = main_q.imm;
    assign out_pc       = main_q.pc;
    assign out_illegal  = main_q.dec.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed cases plus random traffic against a
// mask/match instruction table and a queue model. Honours DECODE_RV32M_EN like the RTL.
module tb_rv_decode_stage;
    import rv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [5:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_we, out_rs1_used, out_rs2_used, out_illegal;

    int passes = 0;
    int total  = 0;
    int pops   = 0;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        op_e         op;
        imm_fmt_e    fmt;
        bit          wr, r1, r2;
    } pat_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic        we, u1, u2, ill;
        logic [31:0] imm;
    } exp_t;

    pat_t tbl[$];
    txn_t q[$];

    rv_decode_stage #(
        .XLEN(32),
        .PC_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_we   (out_rd_we),
        .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic add(input logic [31:0] mask, input logic [31:0] match, input op_e op,
                       input imm_fmt_e fmt, input bit wr, input bit r1, input bit r2);
        pat_t p;
        p.mask = mask; p.match = match; p.op = op; p.fmt = fmt;
        p.wr = wr; p.r1 = r1; p.r2 = r2;
        tbl.push_back(p);
    endtask

    task automatic build_table();
        add(32'h7f, 32'h37, OP_LUI, FMT_U, 1, 0, 0);
        add(32'h7f, 32'h17, OP_AUIPC, FMT_U, 1, 0, 0);
        add(32'h7f, 32'h6f, OP_JAL, FMT_J, 1, 0, 0);
        add(32'h707f, 32'h67, OP_JALR, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h0063, OP_BEQ, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h1063, OP_BNE, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h4063, OP_BLT, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h5063, OP_BGE, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h6063, OP_BLTU, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h7063, OP_BGEU, FMT_B, 0, 1, 1);
        add(32'h707f, 32'h0003, OP_LB, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h1003, OP_LH, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h2003, OP_LW, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h4003, OP_LBU, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h5003, OP_LHU, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h0023, OP_SB, FMT_S, 0, 1, 1);
        add(32'h707f, 32'h1023, OP_SH, FMT_S, 0, 1, 1);
        add(32'h707f, 32'h2023, OP_SW, FMT_S, 0, 1, 1);
        add(32'h707f, 32'h0013, OP_ADDI, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h2013, OP_SLTI, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h3013, OP_SLTIU, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h4013, OP_XORI, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h6013, OP_ORI, FMT_I, 1, 1, 0);
        add(32'h707f, 32'h7013, OP_ANDI, FMT_I, 1, 1, 0);
        add(32'hfe00707f, 32'h00001013, OP_SLLI, FMT_I, 1, 1, 0);
        add(32'hfe00707f, 32'h00005013, OP_SRLI, FMT_I, 1, 1, 0);
        add(32'hfe00707f, 32'h40005013, OP_SRAI, FMT_I, 1, 1, 0);
        add(32'hfe00707f, 32'h00000033, OP_ADD, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h40000033, OP_SUB, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00001033, OP_SLL, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00002033, OP_SLT, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00003033, OP_SLTU, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00004033, OP_XOR, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00005033, OP_SRL, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h40005033, OP_SRA, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00006033, OP_OR, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h00007033, OP_AND, FMT_R, 1, 1, 1);
        add(32'h707f, 32'h000f, OP_FENCE, FMT_I, 0, 0, 0);
        add(32'hffffffff, 32'h00000073, OP_ECALL, FMT_I, 0, 0, 0);
        add(32'hffffffff, 32'h00100073, OP_EBREAK, FMT_I, 0, 0, 0);
`ifdef DECODE_RV32M_EN
        add(32'hfe00707f, 32'h02000033, OP_MUL, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02001033, OP_MULH, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02002033, OP_MULHSU, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02003033, OP_MULHU, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02004033, OP_DIV, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02005033, OP_DIVU, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02006033, OP_REM, FMT_R, 1, 1, 1);
        add(32'hfe00707f, 32'h02007033, OP_REMU, FMT_R, 1, 1, 1);
`endif
    endtask

    // Immediate assembled from the format's bit-scatter rules with shifts and ORs.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input imm_fmt_e f);
        logic [31:0] sx;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (f)
            FMT_I: return (sx << 11) | 32'(i[30:20]);
            FMT_S: return (sx << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
            FMT_B: return (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                          | (32'(i[11:8]) << 1);
            FMT_U: return i & 32'hFFFF_F000;
            FMT_J: return (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                          | (32'(i[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        bit   hit;
        pat_t p;
        hit = 0;
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.op = 6'd0; e.we = 0; e.u1 = 0; e.u2 = 0; e.ill = 1; e.imm = 32'h0;
        foreach (tbl[k]) begin
            if (!hit && ((i & tbl[k].mask) == tbl[k].match)) begin
                hit = 1;
                p = tbl[k];
            end
        end
        if (hit) begin
            e.op  = p.op;
            e.we  = p.wr && (i[11:7] != 5'd0);
            e.u1  = p.r1;
            e.u2  = p.r2;
            e.ill = 0;
            e.imm = ref_imm(i, p.fmt);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned sel;
        logic [31:0] r;
        pat_t        p;
        sel = $urandom_range(0, 9);
        r   = $urandom();
        if (sel < 6) begin
            p = tbl[$urandom_range(0, tbl.size() - 1)];
            return p.match | (r & ~p.mask);
        end else if (sel < 9) begin
            return {r[31:2], 2'b11};
        end
        return r;
    endfunction

    task automatic check_outputs();
        exp_t e;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            e = ref_decode(q[0].instr);
            chk("op", out_op, e.op);
            chk("rd", out_rd, e.rd);
            chk("rs1", out_rs1, e.rs1);
            chk("rs2", out_rs2, e.rs2);
            chk("rd_we", out_rd_we, e.we);
            chk("rs1_used", out_rs1_used, e.u1);
            chk("rs2_used", out_rs2_used, e.u2);
            chk("imm", out_imm, e.imm);
            chk("pc", out_pc, q[0].pc);
            chk("illegal", out_illegal, e.ill);
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit   acc, pp;
        txn_t t;
        @(negedge clk);
        check_outputs();
        acc = in_valid && (q.size() < 2) && !flush;
        pp  = (q.size() != 0) && out_ready;
        t.instr = in_instr;
        t.pc    = in_pc;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pp) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(t);
        end
        #1;
    endtask

    task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b0;
        cycle();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
    endtask

    initial begin
        int pops0;
        build_table();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_op", out_op, 6'd0);
        chk("rst_illegal", out_illegal, 1'b0);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_rd_we", out_rd_we, 1'b0);
        rst = 1'b0;

        send_one(32'hFFF1_0093, 32'h0000_1000);
        chk("addi_op", out_op, OP_ADDI);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_rs1", out_rs1, 5'd2);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_rd_we", out_rd_we, 1'b1);
        chk("addi_rs2_used", out_rs2_used, 1'b0);
        drain();

        send_one(32'hFE00_0EE3, 32'h0000_1004);
        chk("beq_op", out_op, OP_BEQ);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_rd_we", out_rd_we, 1'b0);
        chk("beq_rs1_used", out_rs1_used, 1'b1);
        chk("beq_rs2_used", out_rs2_used, 1'b1);
        drain();

        send_one(32'h1234_52B7, 32'h0000_1008);
        chk("lui_op", out_op, OP_LUI);
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", out_rd, 5'd5);
        drain();

        send_one(32'h0000_0000, 32'h0000_100C);
        chk("ill0_illegal", out_illegal, 1'b1);
        chk("ill0_rd_we", out_rd_we, 1'b0);
        chk("ill0_op", out_op, OP_ILLEGAL);
        drain();
        send_one(32'h0000_707F, 32'h0000_1010);
        chk("ill1_illegal", out_illegal, 1'b1);
        chk("ill1_rd_we", out_rd_we, 1'b0);
        drain();
        send_one(32'h0000_0073, 32'h0000_1014);
        chk("ecall_op", out_op, OP_ECALL);
        chk("ecall_illegal", out_illegal, 1'b0);
        drain();

        send_one(32'h0220_81B3, 32'h0000_1018);
`ifdef DECODE_RV32M_EN
        chk("mul_op", out_op, OP_MUL);
        chk("mul_illegal", out_illegal, 1'b0);
`else
        chk("mul_illegal", out_illegal, 1'b1);
        chk("mul_op", out_op, OP_ILLEGAL);
`endif
        drain();

        // Backpressure: two accepted, third held off while the consumer stalls.
        in_valid = 1'b1; in_instr = 32'h0020_81B3; out_ready = 1'b0;
        in_pc = 32'h100; cycle();
        chk("bp_ready_after_1", in_ready, 1'b1);
        in_pc = 32'h104; cycle();
        chk("bp_ready_after_2", in_ready, 1'b0);
        in_pc = 32'h108; cycle();
        chk("bp_ready_held", in_ready, 1'b0);
        chk("bp_head_pc", out_pc, 32'h100);
        pops0 = pops;
        drain();
        chk("bp_pop_count", pops - pops0, 2);
        chk("bp_empty", out_valid, 1'b0);

        // Flush while full, with a colliding in_valid that must be dropped.
        in_valid = 1'b1; out_ready = 1'b0;
        in_pc = 32'h200; cycle();
        in_pc = 32'h204; cycle();
        chk("fl_full", in_ready, 1'b0);
        flush = 1'b1; in_pc = 32'h208; out_ready = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        cycle();

        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset between clock edges.
        send_one(32'h0020_81B3, 32'h300);
        chk("ar_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_one(32'h0000_0073, 32'h304);
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
